// File: rtl/fifo_i2s_tx.sv
// fifo_i2s_tx: drains WIDTH-bit samples from a playback FIFO onto an I2S link.
// Generates bclk/lrclk from clk, prefetches one word into a holding register and
// emits silence with an underrun pulse whenever a slot starts without a sample.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-low reset
//   fifo_empty    FIFO has no readable word
//   rd            one-cycle pop strobe to the FIFO
//   dout          FIFO read data, valid the cycle after rd
//   bclk          I2S bit clock, period 2*CLK_DIV clk
//   lrclk         I2S word select, 0 = left, 1 = right
//   sdata         I2S serial data, MSB first, one-bit delayed after lrclk
//   underrun      one-cycle pulse when a slot starts without a sample
//   underrun_cnt  saturating count of underrun pulses
module fifo_i2s_tx #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned CLK_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   output logic             rd,
   input  logic [WIDTH-1:0] dout,
   output logic             bclk,
   output logic             lrclk,
   output logic             sdata,
   output logic             underrun,
   output logic [15:0]      underrun_cnt
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRead, StCapture, StFull} state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   divcnt_q, divcnt_d;
   logic [BitW-1:0]   bitcnt_q, bitcnt_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [WIDTH-1:0]  hold_q, hold_d;
   logic              hold_valid_q, hold_valid_d;
   logic              bclk_q, bclk_d;
   logic              lrclk_q, lrclk_d;
   logic              sdata_q, sdata_d;
   logic              rd_q, rd_d;
   logic              underrun_q, underrun_d;
   logic [15:0]       underrun_cnt_q, underrun_cnt_d;

   logic tick;
   logic fall;
   logic boundary;

   always_comb begin
      state_d        = state_q;
      divcnt_d       = divcnt_q;
      bitcnt_d       = bitcnt_q;
      shreg_d        = shreg_q;
      hold_d         = hold_q;
      hold_valid_d   = hold_valid_q;
      bclk_d         = bclk_q;
      lrclk_d        = lrclk_q;
      sdata_d        = sdata_q;
      rd_d           = 1'b0;
      underrun_d     = 1'b0;
      underrun_cnt_d = underrun_cnt_q;

      tick     = (divcnt_q == DivW'(CLK_DIV - 1));
      // bclk is about to go low: data changes on the falling edge
      fall     = tick && bclk_q;
      boundary = fall && (bitcnt_q == BitW'(WIDTH - 1));

      if (tick) begin
         divcnt_d = '0;
         bclk_d   = ~bclk_q;
      end else begin
         divcnt_d = divcnt_q + 1'b1;
      end

      if (fall) begin
         sdata_d = shreg_q[WIDTH-1];
         if (boundary) begin
            lrclk_d  = ~lrclk_q;
            bitcnt_d = '0;
            if (hold_valid_q) begin
               shreg_d      = hold_q;
               hold_valid_d = 1'b0;
            end else begin
               shreg_d    = '0;
               underrun_d = 1'b1;
            end
         end else begin
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q + 1'b1;
         end
      end

      if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
         underrun_cnt_d = underrun_cnt_q + 16'd1;
      end

      // One word in flight at most; a boundary during READ/CAPTURE sees no
      // valid holding word and the in-flight word serves the next slot.
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               state_d = StRead;
               rd_d    = 1'b1;
            end
         end
         StRead: begin
            state_d = StCapture;
         end
         StCapture: begin
            hold_d       = dout;
            hold_valid_d = 1'b1;
            state_d      = StFull;
         end
         StFull: begin
            if (boundary) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= StIdle;
         divcnt_q       <= '0;
         bitcnt_q       <= BitW'(WIDTH - 1);
         shreg_q        <= '0;
         hold_q         <= '0;
         hold_valid_q   <= 1'b0;
         bclk_q         <= 1'b0;
         lrclk_q        <= 1'b1;
         sdata_q        <= 1'b0;
         rd_q           <= 1'b0;
         underrun_q     <= 1'b0;
         underrun_cnt_q <= 16'd0;
      end else begin
         state_q        <= state_d;
         divcnt_q       <= divcnt_d;
         bitcnt_q       <= bitcnt_d;
         shreg_q        <= shreg_d;
         hold_q         <= hold_d;
         hold_valid_q   <= hold_valid_d;
         bclk_q         <= bclk_d;
         lrclk_q        <= lrclk_d;
         sdata_q        <= sdata_d;
         rd_q           <= rd_d;
         underrun_q     <= underrun_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign rd           = rd_q;
   assign bclk         = bclk_q;
   assign lrclk        = lrclk_q;
   assign sdata        = sdata_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_fifo_i2s_tx.sv
// tb_fifo_i2s_tx: bench for fifo_i2s_tx with a FIFO model and a timeline model.
// The model predicts outputs from edge counts since reset: fall events, slot
// boundaries, which popped word fills each slot, and the serial bit stream.
module tb_fifo_i2s_tx;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned CLK_DIV = 2;
   localparam int unsigned BPER    = 2 * CLK_DIV;

   logic             clk = 1'b0;
   logic             rst;
   logic             fifo_empty;
   logic             rd;
   logic [WIDTH-1:0] dout;
   logic             bclk;
   logic             lrclk;
   logic             sdata;
   logic             underrun;
   logic [15:0]      underrun_cnt;

   always #5 clk = ~clk;

   fifo_i2s_tx #(
      .WIDTH   (WIDTH),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .rd           (rd),
      .dout         (dout),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .sdata        (sdata),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   int errors = 0;
   int checks = 0;

   // Model state
   int unsigned      mk;          // non-reset edges since reset release
   bit               have_word;   // a popped word not yet placed in a slot
   logic [15:0]      word_val;
   int unsigned      word_rdk;    // edge after which rd was observed
   logic [15:0]      slot_word[$];
   int unsigned      m_cnt;
   logic [15:0]      fq[$];
   bit               gate_empty;
   bit               pend;
   logic [15:0]      pend_word;

   // Observation logs
   logic             bitlog[$];
   int               rd_pulses;
   int               ur_pulses;
   int               sd_ones;
   logic             prev_bclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, mk, $time);
      end
   endtask

   function automatic logic [15:0] pack(input int base);
      logic [15:0] v = 16'd0;
      for (int i = 0; i < 16; i++) begin
         v = {v[14:0], (base + i < bitlog.size()) ? bitlog[base + i] : 1'b0};
      end
      return v;
   endfunction

   task automatic step();
      logic        e_rd, e_bclk, e_lr, e_sd, e_ur;
      logic [15:0] e_cnt, w;
      int unsigned fl;
      bit          popped;
      @(negedge clk);
      popped = 1'b0;
      if (rst == 1'b0) begin
         e_rd = 0; e_bclk = 0; e_lr = 1; e_sd = 0; e_ur = 0;
         mk = 0; have_word = 0; slot_word.delete(); m_cnt = 0; pend = 0;
      end else begin
         e_rd = !have_word && !fifo_empty;
         e_ur = 1'b0;
         if (mk % BPER == BPER - 1) begin
            fl = (mk + 1) / BPER;
            if ((fl - 1) % WIDTH == 0) begin
               // holding valid needs rd edge + 2 capture cycles before boundary
               if (have_word && mk >= word_rdk + 3) begin
                  slot_word.push_back(word_val);
                  have_word = 1'b0;
               end else begin
                  slot_word.push_back(16'd0);
                  e_ur = 1'b1;
                  if (m_cnt < 32'hFFFF) m_cnt++;
               end
            end
         end
         fl = (mk + 1) / BPER;
         if (fl < 2) begin
            e_sd = 1'b0;
         end else begin
            w    = slot_word[(fl - 2) / WIDTH];
            e_sd = w[WIDTH - 1 - ((fl - 2) % WIDTH)];
         end
         e_lr   = (fl == 0) ? 1'b1 : (((fl - 1) / WIDTH) % 2 == 1);
         e_bclk = (((mk + 1) / CLK_DIV) % 2 == 1);
         if (e_rd) begin
            word_val  = fq.pop_front();
            have_word = 1'b1;
            word_rdk  = mk;
            popped    = 1'b1;
         end
         mk++;
      end
      e_cnt = 16'(m_cnt);
      check("rd", rd, e_rd);
      check("bclk", bclk, e_bclk);
      check("lrclk", lrclk, e_lr);
      check("sdata", sdata, e_sd);
      check("underrun", underrun, e_ur);
      check("underrun_cnt", underrun_cnt, e_cnt);
      if (prev_bclk === 1'b1 && bclk === 1'b0) bitlog.push_back(sdata);
      prev_bclk = bclk;
      if (rd === 1'b1) rd_pulses++;
      if (underrun === 1'b1) ur_pulses++;
      if (sdata === 1'b1) sd_ones++;
      // FIFO answers one cycle after it sees rd; garbage otherwise
      dout       = pend ? pend_word : 16'($urandom);
      pend       = popped;
      pend_word  = word_val;
      fifo_empty = gate_empty || (fq.size() == 0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      repeat (n) step();
      bitlog.delete();
      rd_pulses = 0;
      ur_pulses = 0;
      sd_ones   = 0;
      prev_bclk = 1'b0;
      rst = 1'b1;
   endtask

   initial begin
      int bad;
      int p;
      rst = 1'b0; fifo_empty = 1'b1; dout = '0;
      gate_empty = 0; pend = 0; have_word = 0; mk = 0; m_cnt = 0;
      prev_bclk = 1'b0;

      // Preloaded L/R pair
      fq.delete();
      fq.push_back(16'hA5F0);
      fq.push_back(16'h0F0F);
      do_reset(2);
      repeat (131) step();
      check("t1_rd_pulses", rd_pulses, 2);
      check("t1_no_underrun", ur_pulses, 0);
      repeat (4) step();
      check("t1_left_bits", pack(1), 16'hA5F0);
      check("t1_right_bits", pack(17), 16'h0F0F);
      check("t1_model_left", slot_word[0], 16'hA5F0);
      check("t1_model_right", slot_word[1], 16'h0F0F);

      // Permanently empty
      fq.delete();
      do_reset(1);
      repeat (256) step();
      check("t2_cnt", underrun_cnt, 4);
      check("t2_pulses", ur_pulses, 4);
      check("t2_silence", sd_ones, 0);

      // Word arrives one cycle before the slot-1 boundary (edge 67)
      fq.delete();
      do_reset(1);
      repeat (66) step();
      fq.push_back(16'h8001);
      fifo_empty = 1'b0;
      step();
      check("t3_rd_latency", rd, 1);
      repeat (134) step();
      check("t3_model_slot1", slot_word[1], 16'h0000);
      check("t3_model_slot2", slot_word[2], 16'h8001);
      check("t3_bits", pack(33), 16'h8001);
      check("t3_cnt", underrun_cnt, 3);

      // Continuous supply 1..20
      fq.delete();
      for (int i = 1; i <= 20; i++) fq.push_back(16'(i));
      do_reset(1);
      repeat (1280) step();
      bad = 0;
      for (int i = 0; i < 20; i++) if (slot_word[i] !== 16'(i + 1)) bad++;
      check("t4_order", bad, 0);
      check("t4_no_underrun", ur_pulses, 0);
      check("t4_rd_pulses", rd_pulses, 20);

      // Reset mid-slot
      repeat (37) step();
      rst = 1'b0;
      step();
      check("t5_bclk", bclk, 0);
      check("t5_lrclk", lrclk, 1);
      check("t5_cnt", underrun_cnt, 0);
      rst = 1'b1;
      step();
      check("t5_phase0", bclk, 0);
      step();
      check("t5_phase1", bclk, 1);

      // Saturation
      fq.delete();
      do_reset(1);
      repeat (10) step();
      force dut.underrun_cnt_q = 16'hFFFE;
      #1;
      release dut.underrun_cnt_q;
      m_cnt = 32'hFFFE;
      repeat (192) step();
      check("t6_sat", underrun_cnt, 16'hFFFF);
      check("t6_model_sat", m_cnt, 32'hFFFF);

      // Randomised supply rate with occasional resets
      fq.delete();
      do_reset(1);
      p = 8;
      for (int c = 0; c < 4000; c++) begin
         if (c % 500 == 0) p = (c / 500 % 3 == 0) ? 8 : ((c / 500 % 3 == 1) ? 60 : 100);
         step();
         if ($urandom_range(0, p - 1) == 0 && fq.size() < 4) fq.push_back(16'($urandom));
         gate_empty = ($urandom_range(0, 7) == 0);
         fifo_empty = gate_empty || (fq.size() == 0);
         if ($urandom_range(0, 1999) == 0) begin
            rst = 1'b0;
            step();
            rst = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
